demux_1x8_deser: RTL
====================

# demux_1x8_deser

Sequential 1-to-8 demultiplexing deserializer: the receiving end of an 8:1 mux used as a parallel-to-serial path. It drives the mux select `S` through all WIDTH positions, samples the mux output bit on each clock, and reassembles the original WIDTH-bit word `I`. It sits directly downstream of the `mux_8x1` select/output pair and presents a registered word with a one-cycle valid pulse.

## Interface
- `WIDTH`, default 8: word width; must be a power of two, minimum 2.
- `SEL_W`, default `$clog2(WIDTH)`: select width (3 for WIDTH=8).
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; **asynchronous, active-high**.
- `start`  in  1  request one word capture; sampled on `clk` rising edge.
- `din`  in  1  serial bit; this is the mux output `Y`.
- `S`  out  SEL_W  select driven to the mux; registered.
- `dout`  out  WIDTH  last fully captured word; registered.
- `valid`  out  1  one-cycle pulse: `dout` has just been updated.
- `busy`  out  1  high while a capture is in progress (COLLECT state).

## Operation
- States: IDLE, COLLECT, DONE. Reset state is IDLE.
- IDLE: `busy`=0 and `S`=0. `start`=1 at an edge moves to COLLECT with index `idx`=first index and `S`=`idx`.
- COLLECT: `busy`=1. On each edge, `shadow[idx] <= din`.
  - If `idx` is not the last index, `idx` advances by one and `S` follows.
  - If `idx` is the last index, `dout <= shadow` with the final bit merged in, `valid <= 1`, and the state moves to DONE.
- DONE: `valid`=1 and `busy`=0 for exactly one cycle.
  - With `start`=1 the next edge goes straight to COLLECT (back-to-back).
  - Otherwise the next edge goes to IDLE and `S` returns to 0.
- `start` is ignored while in COLLECT and is not queued.
- `dout` holds its value between completions. An aborted capture never alters it.
- Reset values:
  - All outputs: `S`=0, `dout`=0, `valid`=0, `busy`=0.
  - Internal: `shadow`=0, `idx`=0.
- Reset mid-COLLECT aborts the capture immediately. The partial word is discarded.
- `idx` counts exactly WIDTH positions and never wraps inside one capture.

## Timing
- Edge E0 samples `start`. Capture edges are E1 through E_WIDTH.
- `valid` is high from E_WIDTH to E_WIDTH+1. Latency from `start` to `valid` is WIDTH+1 edges (9 for WIDTH=8).
- `S` is registered and changes right after each edge.
- `din` must be settled before the next edge. The upstream mux is combinational, so there is a full cycle of settling margin.
- With `start` held high, throughput is one word every WIDTH+1 cycles. `S` goes to the first index directly from DONE.
- `rst` assertion clears everything asynchronously. Deassertion must be synchronous to `clk`. The first `start` can be accepted on the first edge after deassertion.

## Configuration
- `DESER_MSB_FIRST_EN`:
  - Defined: capture order is WIDTH-1 down to 0. `S` counts 7,6,…,0 and `idx` decrements.
  - Undefined (default): capture order is 0 up to WIDTH-1. `S` counts 0,1,…,7.
- In both modes:
  - Each sampled bit lands at `dout[S]`, so the captured word is identical.
  - `S` idles at 0.

## Test plan
- Bench setup: a behavioural 8:1 mux model with `din = I[S]` and `I=8'b01100101`. Pulse `start` for one cycle.
  - Required: `S` steps 0..7 on consecutive cycles, `busy`=1 for 8 cycles, `valid`=1 for one cycle 9 edges after `start`, `dout`=8'h65.
- Back-to-back: hold `start`=1 and change `I` to 8'hA3 while the first word is in DONE.
  - Required: second `valid` arrives 9 cycles after the first, `dout`=8'hA3, and `S` returns to 0 with no IDLE cycle.
- Reset mid-capture: assert `rst` when `S`=4 during a capture of 8'hFF that follows a completed 8'h65.
  - Required: `S`, `busy` and `valid` go to 0 immediately and `dout`=0.
  - After release, a new capture of 8'h3C yields `dout`=8'h3C.
- `start` during COLLECT: pulse `start` again at `S`=3.
  - Required: no restart, exactly one `valid`, 9-cycle latency unchanged.
- With `DESER_MSB_FIRST_EN` defined and `I`=8'h65.
  - Required: `S` sequence is 7..0 and `dout`=8'h65.
- Idle hold: after a capture, toggle `din` randomly for 20 cycles with `start`=0.
  - Required: `dout` stays 8'h65, `valid`=0, `S`=0.

Source files
------------

// File: rtl/demux_1x8_deser.sv
// demux_1x8_deser: drives an 8:1 mux select through all positions and reassembles the word (DESER_MSB_FIRST_EN selects descending capture order).
module demux_1x8_deser #(
  parameter int WIDTH = 8,
  parameter int SEL_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             din,
  output logic [SEL_W-1:0] S,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;
`ifdef DESER_MSB_FIRST_EN
  localparam logic [SEL_W-1:0] FIRST = SEL_W'(WIDTH - 1);
  localparam logic [SEL_W-1:0] LAST  = '0;
  localparam logic [SEL_W-1:0] STEP  = '1;
`else
  localparam logic [SEL_W-1:0] FIRST = '0;
  localparam logic [SEL_W-1:0] LAST  = SEL_W'(WIDTH - 1);
  localparam logic [SEL_W-1:0] STEP  = SEL_W'(1);
`endif
  state_t state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] shadow_q, shadow_d, dout_q, dout_d;
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    dout_d   = dout_q;
    case (state_q)
      IDLE: begin
        state_d = start ? COLLECT : IDLE;
        idx_d   = start ? FIRST : '0;
      end
      COLLECT: begin
        shadow_d[idx_q] = din;
        // the last bit is merged straight into dout so valid lines up with it
        dout_d  = (idx_q == LAST) ? shadow_d : dout_q;
        state_d = (idx_q == LAST) ? DONE : COLLECT;
        idx_d   = (idx_q == LAST) ? idx_q : idx_q + STEP;
      end
      DONE: begin
        state_d = start ? COLLECT : IDLE;
        idx_d   = start ? FIRST : '0;
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      shadow_q <= '0;
      dout_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      dout_q   <= dout_d;
    end
  end
  assign S     = idx_q;
  assign dout  = dout_q;
  assign valid = (state_q == DONE);
  assign busy  = (state_q == COLLECT);
endmodule
